// File: rtl/cpu_int_ctl.sv
// Interrupt front-end for the 65C02 core: synchronises IRQ/NMI inputs, masks and
// prioritises them, and presents one request plus vector low byte to ctl.
module cpu_int_ctl #(
    parameter int unsigned NIRQ        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          NMI_EDGE    = 1'b1,
    localparam int unsigned IDW        = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
    input  logic            clk,
    input  logic            RST_n,
    input  logic [NIRQ-1:0] irq_src,
    input  logic            nmi_in,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wd,
    input  logic            RDY,
    input  logic            sync,
    input  logic            I,
    input  logic            take,
    output logic            int_req,
    output logic [7:0]      int_vec,
    output logic            int_nmi,
    output logic [IDW-1:0]  irq_id,
    output logic [NIRQ-1:0] irq_pend
);

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_RST,
        WIN_NMI,
        WIN_IRQ
    } win_t;

    win_t                   win;
    logic [NIRQ-1:0]        irq_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] nmi_sync;
    logic [NIRQ-1:0]        irq_s;
    logic                   nmi_s;
    logic [NIRQ-1:0]        mask;
    logic                   nmi_lat;
    logic                   rst_pend;
    logic                   irq_req;
    logic                   acc;
    logic [IDW-1:0]         irq_win;
    logic                   irq_found;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                irq_sync[i] <= '0;
            end
            nmi_sync <= '0;
        end else begin
            irq_sync[0] <= irq_src;
            nmi_sync[0] <= nmi_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                irq_sync[i] <= irq_sync[i-1];
                nmi_sync[i] <= nmi_sync[i-1];
            end
        end
    end

    assign irq_s = irq_sync[SYNC_STAGES-1];
    assign nmi_s = nmi_sync[SYNC_STAGES-1];

    // Mask and pend stage run regardless of RDY; pend adds the one-edge mask stage.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            mask     <= '1;
            irq_pend <= '0;
        end else begin
            if (mask_we) begin
                mask <= mask_wd;
            end
            irq_pend <= irq_s & mask;
        end
    end

    assign irq_req = (|irq_pend) & ~I;
    assign acc     = take & sync & RDY & int_req;

    generate
        if (NMI_EDGE) begin : g_nmi_edge
            logic nmi_prev;
            logic nmi_edge;

            assign nmi_edge = nmi_s & ~nmi_prev;

            // A fresh edge in the accept cycle must not be lost, so set beats clear.
            always_ff @(posedge clk or negedge RST_n) begin
                if (!RST_n) begin
                    nmi_prev <= 1'b0;
                    nmi_lat  <= 1'b0;
                end else begin
                    nmi_prev <= nmi_s;
                    if (nmi_edge) begin
                        nmi_lat <= 1'b1;
                    end else if (acc && (win == WIN_NMI)) begin
                        nmi_lat <= 1'b0;
                    end
                end
            end
        end else begin : g_nmi_level
            assign nmi_lat = nmi_s;
        end
    endgenerate

    always_comb begin
        win = WIN_NONE;
        if (rst_pend) begin
            win = WIN_RST;
        end else if (nmi_lat) begin
            win = WIN_NMI;
        end else if (irq_req) begin
            win = WIN_IRQ;
        end
    end

    always_comb begin
        int_req = (win != WIN_NONE);
        int_nmi = (win == WIN_NMI);
        case (win)
            WIN_RST: int_vec = VEC_RST;
            WIN_NMI: int_vec = VEC_NMI;
            default: int_vec = VEC_IRQ;
        endcase
    end

    always_comb begin
        irq_win   = '0;
        irq_found = 1'b0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (!irq_found && irq_pend[i]) begin
                irq_win   = IDW'(i);
                irq_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            rst_pend <= 1'b1;
            irq_id   <= '0;
        end else if (acc) begin
            if (win == WIN_RST) begin
                rst_pend <= 1'b0;
            end
            if (win == WIN_IRQ) begin
                irq_id <= irq_win;
            end
        end
    end

endmodule

// File: tb/tb_cpu_int_ctl.sv
// Directed self-checking bench for cpu_int_ctl with default parameters
// (8 IRQs, 2-stage synchronisers, edge-latched NMI).
module tb_cpu_int_ctl;

    logic       clk = 1'b0;
    logic       RST_n;
    logic [7:0] irq_src;
    logic       nmi_in;
    logic       mask_we;
    logic [7:0] mask_wd;
    logic       RDY;
    logic       sync;
    logic       I;
    logic       take;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_nmi;
    logic [2:0] irq_id;
    logic [7:0] irq_pend;

    int errors = 0;
    int checks = 0;

    cpu_int_ctl #(
        .NIRQ        (8),
        .SYNC_STAGES (2),
        .NMI_EDGE    (1'b1)
    ) dut (
        .clk      (clk),
        .RST_n    (RST_n),
        .irq_src  (irq_src),
        .nmi_in   (nmi_in),
        .mask_we  (mask_we),
        .mask_wd  (mask_wd),
        .RDY      (RDY),
        .sync     (sync),
        .I        (I),
        .take     (take),
        .int_req  (int_req),
        .int_vec  (int_vec),
        .int_nmi  (int_nmi),
        .irq_id   (irq_id),
        .irq_pend (irq_pend)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        RST_n = 1'b0; irq_src = '0; nmi_in = 1'b0; mask_we = 1'b0; mask_wd = '0;
        RDY = 1'b1; sync = 1'b0; I = 1'b0; take = 1'b0;
        @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b exp 1", int_req); end
        checks++; if (int_vec !== 8'hFC) begin errors++; $display("FAIL rst_vec: got %h exp fc", int_vec); end
        checks++; if (int_nmi !== 1'b0) begin errors++; $display("FAIL rst_nmi: got %b exp 0", int_nmi); end
        checks++; if (irq_pend !== 8'h00) begin errors++; $display("FAIL rst_pend: got %h exp 00", irq_pend); end
        checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL rst_id: got %0d exp 0", irq_id); end
        RST_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_vec !== 8'hFC) begin errors++; $display("FAIL rst_hold: got req=%b vec=%h exp req=1 vec=fc", int_req, int_vec); end
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rst_taken_req: got %b exp 0", int_req); end
        checks++; if (int_vec !== 8'hFE) begin errors++; $display("FAIL idle_vec: got %h exp fe", int_vec); end
    endtask

    task automatic test_irq;
        irq_src = 8'h24;
        repeat (2) @(negedge clk);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_early: got %b exp 0", int_req); end
        @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_vec !== 8'hFE) begin errors++; $display("FAIL irq_req: got req=%b vec=%h exp req=1 vec=fe", int_req, int_vec); end
        checks++; if (irq_pend !== 8'h24) begin errors++; $display("FAIL irq_pend: got %h exp 24", irq_pend); end
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL irq_id: got %0d exp 2", irq_id); end
        repeat (3) @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL irq_level_hold: got %b exp 1", int_req); end
        I = 1'b1;
        #1;
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_iflag: got %b exp 0", int_req); end
        irq_src = '0;
        repeat (4) @(negedge clk);
        I = 1'b0;
        @(negedge clk);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b exp 0", int_req); end
    endtask

    task automatic test_nmi_over_irq;
        irq_src = 8'h01;
        repeat (3) @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_vec !== 8'hFE) begin errors++; $display("FAIL n3_irq: got req=%b vec=%h exp req=1 vec=fe", int_req, int_vec); end
        nmi_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (int_nmi !== 1'b0) begin errors++; $display("FAIL nmi_early: got %b exp 0", int_nmi); end
        @(negedge clk);
        checks++; if (int_nmi !== 1'b1 || int_vec !== 8'hFA) begin errors++; $display("FAIL nmi_win: got nmi=%b vec=%h exp nmi=1 vec=fa", int_nmi, int_vec); end
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (int_nmi !== 1'b0 || int_vec !== 8'hFE || int_req !== 1'b1) begin errors++; $display("FAIL nmi_then_irq: got nmi=%b vec=%h req=%b exp nmi=0 vec=fe req=1", int_nmi, int_vec, int_req); end
        checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL nmi_take_id: got %0d exp 2", irq_id); end
        repeat (5) @(negedge clk);
        checks++; if (int_nmi !== 1'b0) begin errors++; $display("FAIL nmi_level_retrig: got %b exp 0", int_nmi); end
        nmi_in = 1'b0; irq_src = '0;
        repeat (4) @(negedge clk);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL n3_idle: got %b exp 0", int_req); end
    endtask

    task automatic test_back_to_back;
        nmi_in = 1'b1;
        @(negedge clk); nmi_in = 1'b0;
        @(negedge clk); nmi_in = 1'b1;
        @(negedge clk); nmi_in = 1'b0;
        checks++; if (int_nmi !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b exp 1", int_nmi); end
        @(negedge clk);
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (int_req !== 1'b1 || int_nmi !== 1'b1 || int_vec !== 8'hFA) begin errors++; $display("FAIL b2b_setwins: got req=%b nmi=%b vec=%h exp req=1 nmi=1 vec=fa", int_req, int_nmi, int_vec); end
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b exp 0", int_req); end
    endtask

    task automatic test_rdy_stall;
        RDY = 1'b0; take = 1'b1; sync = 1'b1; nmi_in = 1'b1;
        @(negedge clk);
        nmi_in = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (int_nmi !== 1'b1) begin errors++; $display("FAIL rdy_latch: got %b exp 1", int_nmi); end
        repeat (5) @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_nmi !== 1'b1 || int_vec !== 8'hFA) begin errors++; $display("FAIL rdy_hold: got req=%b nmi=%b vec=%h exp req=1 nmi=1 vec=fa", int_req, int_nmi, int_vec); end
        checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL rdy_id: got %0d exp 2", irq_id); end
        take = 1'b0; sync = 1'b0; RDY = 1'b1;
        @(negedge clk);
        checks++; if (int_nmi !== 1'b1) begin errors++; $display("FAIL rdy_resume: got %b exp 1", int_nmi); end
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL rdy_served: got %b exp 0", int_req); end
    endtask

    task automatic test_mask_and_reset;
        mask_we = 1'b1; mask_wd = 8'hFB; irq_src = 8'h04;
        @(negedge clk);
        mask_we = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (irq_pend !== 8'h00 || int_req !== 1'b0) begin errors++; $display("FAIL mask_block: got pend=%h req=%b exp pend=00 req=0", irq_pend, int_req); end
        irq_src = 8'h0C;
        repeat (3) @(negedge clk);
        checks++; if (irq_pend !== 8'h08 || int_req !== 1'b1 || int_vec !== 8'hFE) begin errors++; $display("FAIL mask_pass: got pend=%h req=%b vec=%h exp pend=08 req=1 vec=fe", irq_pend, int_req, int_vec); end
        take = 1'b1; sync = 1'b1;
        #2 RST_n = 1'b0;
        #1;
        checks++; if (int_req !== 1'b1 || int_vec !== 8'hFC || int_nmi !== 1'b0) begin errors++; $display("FAIL midrst_out: got req=%b vec=%h nmi=%b exp req=1 vec=fc nmi=0", int_req, int_vec, int_nmi); end
        checks++; if (irq_pend !== 8'h00 || irq_id !== 3'd0) begin errors++; $display("FAIL midrst_state: got pend=%h id=%0d exp pend=00 id=0", irq_pend, irq_id); end
        @(negedge clk);
        take = 1'b0; sync = 1'b0; RST_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (irq_pend !== 8'h0C || int_vec !== 8'hFC) begin errors++; $display("FAIL midrst_mask: got pend=%h vec=%h exp pend=0c vec=fc", irq_pend, int_vec); end
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (int_req !== 1'b1 || int_vec !== 8'hFE || irq_id !== 3'd0) begin errors++; $display("FAIL post_rst_irq: got req=%b vec=%h id=%0d exp req=1 vec=fe id=0", int_req, int_vec, irq_id); end
        take = 1'b1; sync = 1'b1;
        @(negedge clk);
        take = 1'b0; sync = 1'b0;
        checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL post_rst_id: got %0d exp 2", irq_id); end
    endtask

    initial begin
        test_reset;
        test_irq;
        test_nmi_over_irq;
        test_back_to_back;
        test_rdy_stall;
        test_mask_and_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
